// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server
//   Serves HPS upload reads for one ioctl_index by halting the core CPU and
//   fetching each requested byte from core RAM with a fixed read latency.
//
// Ports
//   clk_sys       in   system clock (all flops on rising edge)
//   reset         in   synchronous active-high reset
//   ioctl_upload  in   HPS upload session active
//   ioctl_index   in   [7:0]  upload target index
//   ioctl_addr    in   [24:0] requested byte offset
//   ioctl_rd      in   one-cycle request strobe
//   ioctl_din     out  [7:0]  byte returned to the HPS
//   ioctl_wait    out  HPS stall
//   ram_addr      out  [15:0] core RAM read address
//   ram_rd        out  one-cycle core RAM read strobe
//   ram_dout      in   [7:0]  core RAM read data
//   pause_req     out  CPU halt request for the session
//   paused        in   CPU halt acknowledge
//   bytes_served  out  [15:0] in-range bytes delivered this session
module ioctl_upload_server #(
    parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter logic [15:0] LENGTH       = 16'd256,
    parameter int          RD_LATENCY   = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic        ram_rd,
    input  logic [7:0]  ram_dout,
    output logic        pause_req,
    input  logic        paused,
    output logic [15:0] bytes_served
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALT  = 2'd1,
        ARMED = 2'd2,
        FETCH = 2'd3
    } state_t;

    // Capture happens on the edge that closes the RD_LATENCY-th cycle after ram_rd.
    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    state_t      state_r, state_s;
    logic        upload_prev_r;
    // Set once ioctl_upload has been seen low; an upload already high when
    // reset releases must not look like a fresh session start.
    logic        upload_low_seen_r;
    logic [2:0]  lat_cnt_r, lat_cnt_s;
    logic [7:0]  din_s;
    logic        wait_s;
    logic [15:0] addr_s;
    logic        rd_s;
    logic        pause_s;
    logic [15:0] bytes_s;

    logic        upload_rise_s;
    logic        upload_fall_s;
    logic        in_range_s;

    assign upload_rise_s = ioctl_upload & ~upload_prev_r & upload_low_seen_r;
    assign upload_fall_s = upload_prev_r & ~ioctl_upload;
    assign in_range_s    = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] < LENGTH);

    // Next-state and next-output decode.
    always_comb begin
        state_s   = state_r;
        lat_cnt_s = lat_cnt_r;
        din_s     = ioctl_din;
        wait_s    = ioctl_wait;
        addr_s    = ram_addr;
        rd_s      = 1'b0;
        pause_s   = pause_req;
        bytes_s   = bytes_served;

        case (state_r)
            IDLE: begin
                if (upload_rise_s && (ioctl_index == UPLOAD_INDEX)) begin
                    state_s = HALT;
                    pause_s = 1'b1;
                    wait_s  = 1'b1;
                    bytes_s = 16'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            HALT: begin
                if (upload_fall_s) begin
                    state_s = IDLE;
                    pause_s = 1'b0;
                    wait_s  = 1'b0;
                end else if (paused) begin
                    state_s = ARMED;
                    wait_s  = 1'b0;
                end else begin
                    wait_s  = 1'b1;
                end
            end
            ARMED: begin
                if (upload_fall_s) begin
                    state_s = IDLE;
                    pause_s = 1'b0;
                    wait_s  = 1'b0;
                end else if (!paused) begin
                    state_s = HALT;
                    wait_s  = 1'b1;
                end else if (ioctl_rd) begin
                    if (in_range_s) begin
                        state_s   = FETCH;
                        addr_s    = BASE_ADDR + ioctl_addr[15:0];
                        rd_s      = 1'b1;
                        wait_s    = 1'b1;
                        lat_cnt_s = 3'd0;
                    end else begin
                        din_s     = 8'hFF;
                    end
                end else begin
                    state_s = ARMED;
                end
            end
            FETCH: begin
                if (upload_fall_s) begin
                    state_s = IDLE;
                    pause_s = 1'b0;
                    wait_s  = 1'b0;
                end else if (!paused) begin
                    // Fetch is dropped; the byte is re-requested after the halt returns.
                    state_s = HALT;
                    wait_s  = 1'b1;
                end else if (lat_cnt_r == LAT_LAST) begin
                    state_s = ARMED;
                    din_s   = ram_dout;
                    wait_s  = 1'b0;
                    bytes_s = (bytes_served != 16'hFFFF) ? (bytes_served + 16'd1) : bytes_served;
                end else begin
                    lat_cnt_s = lat_cnt_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
                pause_s = 1'b0;
                wait_s  = 1'b0;
            end
        endcase
    end

    // State, edge detector and registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r           <= IDLE;
            upload_prev_r     <= 1'b0;
            upload_low_seen_r <= ~ioctl_upload;
            lat_cnt_r         <= 3'd0;
            ioctl_din         <= 8'h00;
            ioctl_wait        <= 1'b0;
            ram_addr          <= 16'h0000;
            ram_rd            <= 1'b0;
            pause_req         <= 1'b0;
            bytes_served      <= 16'd0;
        end else begin
            state_r           <= state_s;
            upload_prev_r     <= ioctl_upload;
            upload_low_seen_r <= upload_low_seen_r | ~ioctl_upload;
            lat_cnt_r         <= lat_cnt_s;
            ioctl_din         <= din_s;
            ioctl_wait        <= wait_s;
            ram_addr          <= addr_s;
            ram_rd            <= rd_s;
            pause_req         <= pause_s;
            bytes_served      <= bytes_s;
        end
    end

endmodule

// File: doc/ioctl_upload_server.md
IOCTL_UPLOAD_SERVER -- requirements
Module: ioctl_upload_server

Interface
REQ-001 Parameter UPLOAD_INDEX, default 8'd4: ioctl_index value that this block serves.
REQ-002 Parameter BASE_ADDR, default 16'h0000: core RAM address that maps to upload byte 0.
REQ-003 Parameter LENGTH, default 16'd256: number of valid upload bytes.
REQ-004 Parameter RD_LATENCY, default 2: number of clocks from ram_rd until ram_dout is valid (1..7).
REQ-005 clk_sys  in  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-006 reset  in  1  reset; synchronous, active-high.
REQ-007 ioctl_upload  in  1  HPS upload session active.
REQ-008 ioctl_index  in  8  upload target index.
REQ-009 ioctl_addr  in  25  byte offset requested by the HPS.
REQ-010 ioctl_rd  in  1  one-cycle request strobe for the byte at ioctl_addr.
REQ-011 ioctl_din  out  8  byte returned to the HPS.
REQ-012 ioctl_wait  out  1  high while the HPS must stall.
REQ-013 ram_addr  out  16  core RAM read address.
REQ-014 ram_rd  out  1  one-cycle core RAM read strobe.
REQ-015 ram_dout  in  8  core RAM read data.
REQ-016 pause_req  out  1  requests a CPU halt for the duration of the session.
REQ-017 paused  in  1  CPU halt acknowledged.
REQ-018 bytes_served  out  16  count of in-range bytes delivered in the current session.

Function
REQ-019 The state machine SHALL have the states IDLE, HALT, ARMED and FETCH.
REQ-020 A session SHALL start on a rising edge of ioctl_upload (registered previous value) with ioctl_index==UPLOAD_INDEX: transition IDLE->HALT, pause_req=1, ioctl_wait=1; any other index SHALL leave the block in IDLE with all outputs unchanged.
REQ-021 HALT->ARMED SHALL occur on the first cycle paused==1; ioctl_wait SHALL drop to 0 in ARMED; pause_req SHALL stay 1 in HALT, ARMED and FETCH.
REQ-022 In ARMED, ioctl_rd with ioctl_addr<LENGTH: ram_addr=BASE_ADDR+ioctl_addr[15:0] (16-bit wrap), ram_rd=1 for exactly one cycle, ioctl_wait=1 in the next cycle, then transition to FETCH.
REQ-023 FETCH SHALL count RD_LATENCY cycles after ram_rd, then capture ram_dout into ioctl_din, drop ioctl_wait, increment bytes_served (saturating at 16'hFFFF), and return to ARMED.
REQ-024 Request-to-data latency SHALL be RD_LATENCY+1 clocks from ioctl_rd to ioctl_wait low with valid ioctl_din.
REQ-025 In ARMED, ioctl_rd with ioctl_addr>=LENGTH (any bit of [24:16] set counts as out of range): ioctl_din=8'hFF on the next cycle, no ram_rd, no ioctl_wait, and no bytes_served change.
REQ-026 ioctl_rd in IDLE, HALT or FETCH SHALL be ignored.
REQ-027 A falling edge of ioctl_upload in any non-IDLE state SHALL abort immediately: next cycle IDLE, pause_req=0, ioctl_wait=0, ram_rd=0; an in-flight FETCH result SHALL be discarded.
REQ-028 ioctl_upload falling in the same cycle as ioctl_rd SHALL take precedence (abort, no ram_rd).
REQ-029 paused dropping during ARMED/FETCH SHALL return to HALT (ioctl_wait=1, in-flight fetch discarded, no increment) until paused returns.
REQ-030 bytes_served SHALL clear to 0 on each session start and hold its value in IDLE.
REQ-031 ioctl_din SHALL hold its last value between requests.

Reset
REQ-032 While reset=1: state IDLE, ioctl_din=8'h00, ioctl_wait=0, ram_addr=0, ram_rd=0, pause_req=0, bytes_served=0, edge-detect register=0.
REQ-033 Reset asserted mid-session SHALL behave as REQ-032 on the next edge; an ioctl_upload already high when reset releases SHALL NOT start a session (no rising edge seen).

Verification
REQ-034 Upload index 4, paused tied to 1 cycle after pause_req, rd addr 0x05, RAM[0x05]=0xA5 -> ram_addr=0x0005, one ram_rd pulse, ioctl_wait high 2 cycles, ioctl_din=0xA5 at cycle 3, bytes_served=1.
REQ-035 Upload index 3 -> pause_req stays 0, ioctl_wait stays 0, rd strobes produce no ram_rd.
REQ-036 In ARMED, rd addr 0x100 and 0x10000 -> ioctl_din=0xFF, no ram_rd, no wait, bytes_served unchanged.
REQ-037 ioctl_upload drops 1 cycle after ram_rd -> next cycle IDLE, pause_req=0, ioctl_wait=0, ioctl_din unchanged.
REQ-038 paused held low for 10 cycles after session start -> ioctl_wait=1 throughout, rd strobes ignored; ARMED one cycle after paused=1.
REQ-039 BASE_ADDR=16'hFFF0, rd addr 0x20 -> ram_addr=16'h0010.
